// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: responder for the core's dmem port.
// Serves a word-addressed space made of a synchronous data RAM and a small
// MMIO window: a free-running cycle counter (CTR), a TX byte FIFO drained
// over a ready/valid port (TXD), and a status/control register (STAT).
//
// Ports:
//   clock        master clock, rising-edge
//   reset        asynchronous active-high reset
//   address_dmem word address from the core
//   data         write data from the core
//   wren         write enable from the core
//   q_dmem       registered read data (1-edge latency)
//   tx_data      byte at the FIFO head
//   tx_valid     FIFO non-empty
//   tx_ready     consumer accepts tx_data this cycle
//   bus_err      sticky unmapped-write flag
//
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag writes to unmapped
// addresses on bus_err / STAT bit3. Without it, bus_err is tied to 0.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Address decode
  logic is_ram;
  logic is_ctr;
  logic is_txd;
  logic is_stat;
  logic is_unmapped;

  always_comb begin
    is_ram      = (address_dmem < 32'(DEPTH));
    is_ctr      = (address_dmem == MMIO_BASE);
    is_txd      = (address_dmem == (MMIO_BASE + 32'd1));
    is_stat     = (address_dmem == (MMIO_BASE + 32'd2));
    is_unmapped = ~(is_ram | is_ctr | is_txd | is_stat);
  end

  // Data RAM: no reset; read path samples the old word (read-first)
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ram_rdata;

  always_comb ram_rdata = ram_mem[address_dmem[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wren && is_ram) ram_mem[address_dmem[AW-1:0]] <= data;
  end

  // State registers
  logic [31:0] q_dmem_q,  q_dmem_d;
  logic [31:0] ctr_q,     ctr_d;
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [7:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic        ovf_q,     ovf_d;
  logic        stat_bus_err;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push;
  logic pop;
  logic stat_wr;
  logic [31:0] stat_val;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    tx_valid   = ~fifo_empty;
    tx_data    = fifo_mem_q[rd_ptr_q];
    pop        = tx_valid & tx_ready;
    push_req   = wren & is_txd;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push       = push_req & (~fifo_full | pop);
    stat_wr    = wren & is_stat;
    stat_val   = {20'b0, 4'(count_q), 4'b0, stat_bus_err, ovf_q, fifo_full, fifo_empty};
  end

  // Next-state logic for counter, FIFO, flags and read data
  always_comb begin
    ctr_d      = ctr_q + 32'd1;
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    q_dmem_d   = 32'b0;

    if (wren && is_ctr) ctr_d = data;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = data[7:0];
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (stat_wr && data[2]) ovf_d = 1'b0;

    if (is_ram)       q_dmem_d = ram_rdata;
    else if (is_ctr)  q_dmem_d = ctr_q;
    else if (is_txd)  q_dmem_d = {24'b0, tx_data};
    else if (is_stat) q_dmem_d = stat_val;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_dmem_q <= 32'b0;
      ctr_q    <= 32'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= 8'b0;
    end else begin
      q_dmem_q <= q_dmem_d;
      ctr_q    <= ctr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

  assign q_dmem = q_dmem_q;

`ifdef DMEM_BOUNDS_CHECK_EN
  // Sticky unmapped-write flag, cleared by a STAT write with data[3]=1
  logic bus_err_q, bus_err_d;

  always_comb begin
    bus_err_d = bus_err_q;
    if (wren && is_unmapped) bus_err_d = 1'b1;
    if (stat_wr && data[3])  bus_err_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end

  assign stat_bus_err = bus_err_q;
  assign bus_err      = bus_err_q;
`else
  logic unused_unmapped;
  assign unused_unmapped = is_unmapped;
  assign stat_bus_err    = 1'b0;
  assign bus_err         = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder. Read expectations go through a
// scoreboard queue popped when q_dmem is sampled; TX bytes are predicted by
// a reference FIFO model and compared at each handshake.
module tb_dmem_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_CTR  = BASE;
  localparam logic [31:0] A_TXD  = BASE + 32'd1;
  localparam logic [31:0] A_STAT = BASE + 32'd2;
  localparam logic [31:0] A_IDLE = 32'h0000_3000;
  localparam int unsigned FD = 4;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BE_EXP = 1'b1;
`else
  localparam logic BE_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = 32'b0;
  logic [31:0] data = 32'b0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rdq [$];
  logic [7:0]  txq [$];

  always #5 clock = ~clock;

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .bus_err      (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive just after a falling edge, sample at the next one
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic chk, input logic [31:0] exp);
    logic was_full;
    logic popped;
    logic [7:0] exp_b;
    address_dmem = a;
    data         = d;
    wren         = w;
    if (chk) rdq.push_back(exp);
    check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    was_full = (txq.size() == FD);
    popped   = tx_valid && tx_ready;
    if (popped) begin
      exp_b = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
      check("tx_byte", 32'(tx_data), 32'(exp_b));
    end
    if (w && a == A_TXD && (!was_full || popped)) txq.push_back(d[7:0]);
    @(negedge clock);
    wren = 1'b0;
    if (chk) check("q_dmem", q_dmem, rdq.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(A_IDLE, 32'b0, 1'b0, 1'b1, 32'b0);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_q_dmem", q_dmem, 32'b0);
    check("rst_tx_valid", 32'(tx_valid), 32'b0);
    check("rst_tx_data", 32'(tx_data), 32'b0);
    check("rst_bus_err", 32'(bus_err), 32'b0);
    reset = 1'b0;

    // Counter: 10 idle edges, then read
    idle(10);
    access(A_CTR, 32'b0, 1'b0, 1'b1, 32'd10);
    access(A_CTR, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd11);
    access(A_CTR, 32'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    access(A_CTR, 32'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    access(A_CTR, 32'b0, 1'b0, 1'b1, 32'h0000_0000);

    // RAM write, read, read-first on same-index write
    access(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'b0);
    access(32'd5, 32'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    access(32'd5, 32'd1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    access(32'd5, 32'b0, 1'b0, 1'b1, 32'd1);
    access(32'd4095, 32'h1234_5678, 1'b1, 1'b0, 32'b0);
    access(32'd4095, 32'b0, 1'b0, 1'b1, 32'h1234_5678);
    access(BASE + 32'd3, 32'b0, 1'b0, 1'b1, 32'b0);
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);

    // FIFO order and backpressure
    tx_ready = 1'b0;
    access(A_TXD, 32'hFFFF_FF41, 1'b1, 1'b0, 32'b0);
    access(A_TXD, 32'h0000_0042, 1'b1, 1'b0, 32'b0);
    access(A_TXD, 32'h0000_0043, 1'b1, 1'b0, 32'b0);
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0300);
    check("head_byte", 32'(tx_data), 32'h41);
    access(A_TXD, 32'b0, 1'b0, 1'b1, 32'h0000_0041);
    tx_ready = 1'b1;
    idle(3);
    tx_ready = 1'b0;
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);
    check("drain_done", 32'(txq.size()), 32'd0);

    // Overflow: fifth byte dropped, ovf set, then cleared
    for (int i = 0; i < 5; i++) access(A_TXD, 32'(8'h10 + i), 1'b1, 1'b0, 32'b0);
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0406);
    tx_ready = 1'b1;
    idle(5);
    tx_ready = 1'b0;
    access(A_STAT, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0005);
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) access(A_TXD, 32'(8'h20 + i), 1'b1, 1'b0, 32'b0);
    tx_ready = 1'b1;
    access(A_TXD, 32'h0000_0055, 1'b1, 1'b0, 32'b0);
    tx_ready = 1'b0;
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0402);
    tx_ready = 1'b1;
    idle(4);
    tx_ready = 1'b0;
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);
    check("drain_done2", 32'(txq.size()), 32'd0);

    // Reset mid-traffic
    access(A_TXD, 32'h61, 1'b1, 1'b0, 32'b0);
    access(A_TXD, 32'h62, 1'b1, 1'b0, 32'b0);
    access(32'd5, 32'b0, 1'b0, 1'b1, 32'd1);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'b0);
    check("async_q_dmem", q_dmem, 32'b0);
    check("async_tx_data", 32'(tx_data), 32'b0);
    txq.delete();
    @(negedge clock);
    reset = 1'b0;
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);
    access(32'd5, 32'b0, 1'b0, 1'b1, 32'd1);

    // Unmapped write and bus_err
    access(32'h0000_2000, 32'hCAFE_0000, 1'b1, 1'b1, 32'b0);
    check("bus_err_set", 32'(bus_err), 32'(BE_EXP));
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001 | (32'(BE_EXP) << 3));
    access(A_STAT, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0001 | (32'(BE_EXP) << 3));
    check("bus_err_clr", 32'(bus_err), 32'b0);
    access(A_STAT, 32'b0, 1'b0, 1'b1, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
